// File: rtl/instr_sequencer_pkg.sv
// Shared types for the multi-cycle instruction sequencer: state encoding, opcodes, op classes.
// SEQ_STEP_EN adds the single-step STEP_WAIT state.
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WB    = 3'd3,
        S_HALT  = 3'd4
`ifdef SEQ_STEP_EN
        , S_STEP_WAIT = 3'd5
`endif
    } seq_state_t;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_ROTR  = 3'b001;
    localparam logic [2:0] OP_NAND  = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_STORE = 3'b100;
    localparam logic [2:0] OP_MOVE  = 3'b101;
    localparam logic [2:0] OP_BNE   = 3'b110;
    localparam logic [2:0] OP_SET   = 3'b111;

    typedef enum logic [1:0] {
        CLS_REG    = 2'd0,
        CLS_LOAD   = 2'd1,
        CLS_STORE  = 2'd2,
        CLS_BRANCH = 2'd3
    } op_class_t;

    function automatic op_class_t op_class(input logic [2:0] op);
        case (op)
            OP_LOAD:  return CLS_LOAD;
            OP_STORE: return CLS_STORE;
            OP_BNE:   return CLS_BRANCH;
            default:  return CLS_REG;
        endcase
    endfunction

endpackage

// File: rtl/instr_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/EXEC/WB sequencer with halt address, cycle watchdog and retire counter.
// Define SEQ_STEP_EN to pause in STEP_WAIT after every non-halting retire until step is seen.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int MCODEBITS  = 3,
    parameter int PC_W       = 10,
    parameter int CNT_W      = 16,
    parameter int MAX_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 step,
    input  logic [MCODEBITS-1:0] opcode,
    input  logic [PC_W-1:0]      pc,
    input  logic [PC_W-1:0]      halt_addr,
    input  logic                 branch_taken,
    output logic                 pc_rst,
    output logic                 pc_en,
    output logic                 pc_load,
    output logic                 ir_en,
    output logic                 reg_we,
    output logic                 mem_re,
    output logic                 mem_we,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [CNT_W-1:0]     instr_count,
    output logic [CNT_W-1:0]     cycle_count
);

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);

    seq_state_t           state_q, state_d;
    logic [MCODEBITS-1:0] op_q;
    logic                 timeout_q;
    logic                 run, retire, cnt_clear, wd_hit;

`ifndef SEQ_STEP_EN
    logic unused_step;
    assign unused_step = step;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH) begin
                op_q <= opcode;
            end
            if (cnt_clear) begin
                timeout_q <= 1'b0;
            end else if (wd_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_rst    = 1'b0;
        pc_en     = 1'b0;
        pc_load   = 1'b0;
        ir_en     = 1'b0;
        reg_we    = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        run       = 1'b0;
        retire    = 1'b0;
        cnt_clear = 1'b0;
        wd_hit    = 1'b0;

        case (state_q)
            S_IDLE, S_HALT: begin
                // start feeds pc_rst directly, so keep it quiet while reset is held
                if (start && rst_n) begin
                    pc_rst    = 1'b1;
                    cnt_clear = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                run     = 1'b1;
                ir_en   = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                run = 1'b1;
                case (op_class(op_q))
                    CLS_LOAD: begin
                        mem_re  = 1'b1;
                        state_d = S_WB;
                    end
                    CLS_STORE: begin
                        mem_we = 1'b1;
                        retire = 1'b1;
                    end
                    CLS_BRANCH: retire = 1'b1;
                    default: begin
                        reg_we = 1'b1;
                        retire = 1'b1;
                    end
                endcase
            end
            S_WB: begin
                run    = 1'b1;
                mem_re = 1'b1;
                reg_we = 1'b1;
                retire = 1'b1;
            end
`ifdef SEQ_STEP_EN
            S_STEP_WAIT: begin
                run = 1'b1;
                if (step) begin
                    state_d = S_FETCH;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (retire) begin
            if (pc == halt_addr) begin
                state_d = S_HALT;
            end else begin
`ifdef SEQ_STEP_EN
                state_d = S_STEP_WAIT;
`else
                state_d = S_FETCH;
`endif
                if ((op_class(op_q) == CLS_BRANCH) && branch_taken) begin
                    pc_load = 1'b1;
                end else begin
                    pc_en = 1'b1;
                end
            end
        end

        // watchdog overrides the retire destination but leaves this cycle's strobes intact
        if (run && (cycle_count == WD_LAST)) begin
            wd_hit  = 1'b1;
            state_d = S_HALT;
        end
    end

    assign busy    = run;
    assign done    = (state_q == S_HALT);
    assign timeout = timeout_q;

    sat_counter #(.CNT_W(CNT_W)) u_instr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .inc   (retire),
        .count (instr_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .inc   (run),
        .count (cycle_count)
    );

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: cycle-level reference model feeding a scoreboard, plus directed checks.
module tb_instr_sequencer;

    localparam int PC_W  = 10;
    localparam int CNT_W = 16;
    localparam int MAXC  = 16;
`ifdef SEQ_STEP_EN
    localparam int SW = 1;
`else
    localparam int SW = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n, start, step, branch_taken;
    logic [2:0]       opcode;
    logic [PC_W-1:0]  pc, halt_addr;
    logic             pc_rst, pc_en, pc_load, ir_en, reg_we, mem_re, mem_we;
    logic             busy, done, timeout;
    logic [CNT_W-1:0] instr_count, cycle_count;

    instr_sequencer #(
        .MCODEBITS  (3),
        .PC_W       (PC_W),
        .CNT_W      (CNT_W),
        .MAX_CYCLES (MAXC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .step         (step),
        .opcode       (opcode),
        .pc           (pc),
        .halt_addr    (halt_addr),
        .branch_taken (branch_taken),
        .pc_rst       (pc_rst),
        .pc_en        (pc_en),
        .pc_load      (pc_load),
        .ir_en        (ir_en),
        .reg_we       (reg_we),
        .mem_re       (mem_re),
        .mem_we       (mem_we),
        .busy         (busy),
        .done         (done),
        .timeout      (timeout),
        .instr_count  (instr_count),
        .cycle_count  (cycle_count)
    );

    always #5 clk = ~clk;

    typedef enum {T_IDLE, T_FETCH, T_EXEC, T_WB, T_HALT, T_STEP} tstate_e;

    tstate_e         m_st;
    logic [2:0]      m_op;
    logic [15:0]     m_ic, m_cc;
    logic            m_to;
    logic [2:0]      imem [0:15];
    logic [PC_W-1:0] br_target;
    logic [63:0]     sb [$];

    int          n_chk = 0, n_pass = 0;
    int          n_pcrst, n_pcen, n_pcload, n_busy;
    logic [31:0] ir_mask, re_mask, we_mask;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic m_reset();
        m_st = T_IDLE;
        m_op = 3'd0;
        m_ic = 16'd0;
        m_cc = 16'd0;
        m_to = 1'b0;
        sb.delete();
    endtask

    function automatic logic [41:0] dut_vec();
        return {pc_rst, pc_en, pc_load, ir_en, reg_we, mem_re, mem_we,
                busy, done, timeout, instr_count, cycle_count};
    endfunction

    // One clock: called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic cycle(input int idx);
        logic    e_rst, e_en, e_ld, e_ir, e_we, e_re, e_mw, e_run, e_ret, e_wd;
        tstate_e nx;
        opcode = imem[pc[3:0]];
        #2;
        e_rst = 0; e_en = 0; e_ld = 0; e_ir = 0; e_we = 0; e_re = 0; e_mw = 0; e_ret = 0;
        nx    = m_st;
        e_run = (m_st == T_FETCH) || (m_st == T_EXEC) || (m_st == T_WB) || (m_st == T_STEP);
        case (m_st)
            T_IDLE, T_HALT: if (start) begin e_rst = 1; nx = T_FETCH; end
            T_FETCH: begin e_ir = 1; nx = T_EXEC; end
            T_EXEC: begin
                if (m_op == 3'd3) begin
                    e_re = 1; nx = T_WB;
                end else begin
                    e_ret = 1;
                    if (m_op == 3'd4) e_mw = 1;
                    else if (m_op != 3'd6) e_we = 1;
                end
            end
            T_WB: begin e_re = 1; e_we = 1; e_ret = 1; end
            T_STEP: if (step) nx = T_FETCH;
            default: ;
        endcase
        if (e_ret) begin
            if (pc == halt_addr) begin
                nx = T_HALT;
            end else begin
                nx = (SW == 1) ? T_STEP : T_FETCH;
                if ((m_op == 3'd6) && branch_taken) e_ld = 1;
                else e_en = 1;
            end
        end
        e_wd = e_run && (m_cc == 16'(MAXC - 1));
        if (e_wd) nx = T_HALT;

        sb.push_back({22'd0, e_rst, e_en, e_ld, e_ir, e_we, e_re, e_mw,
                      e_run, (m_st == T_HALT), m_to, m_ic, m_cc});
        check("cyc", {22'd0, dut_vec()}, sb.pop_front());

        if (pc_rst)  n_pcrst++;
        if (pc_en)   n_pcen++;
        if (pc_load) n_pcload++;
        if (busy)    n_busy++;
        if (idx < 32) begin
            if (ir_en)  ir_mask[idx] = 1'b1;
            if (mem_re) re_mask[idx] = 1'b1;
            if (reg_we) we_mask[idx] = 1'b1;
        end

        @(posedge clk);
        #1;
        if (m_st == T_FETCH) m_op = opcode;
        if (e_rst) begin
            m_ic = 16'd0; m_cc = 16'd0; m_to = 1'b0;
        end else begin
            if (e_ret && (m_ic != 16'hFFFF)) m_ic = m_ic + 16'd1;
            if (e_run && (m_cc != 16'hFFFF)) m_cc = m_cc + 16'd1;
            if (e_wd) m_to = 1'b1;
        end
        m_st = nx;
        if (e_rst)     pc = '0;
        else if (e_ld) pc = br_target;
        else if (e_en) pc = pc + 1'b1;
        @(negedge clk);
    endtask

    task automatic run_prog(input int bound);
        n_pcrst = 0; n_pcen = 0; n_pcload = 0; n_busy = 0;
        ir_mask = '0; re_mask = '0; we_mask = '0;
        start = 1'b1;
        cycle(0);
        start = 1'b0;
        for (int i = 1; i < bound && m_st != T_HALT; i++) cycle(i);
        check("halt_reached", done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n = 0; start = 0; step = 0; branch_taken = 0;
        pc = '0; halt_addr = '0; opcode = '0; br_target = '0;
        for (int i = 0; i < 16; i++) imem[i] = 3'd0;
        m_reset();

        @(negedge clk);
        #2;
        check("rst_out", {22'd0, dut_vec()}, 64'd0);
        @(negedge clk);
        rst_n = 1;

        // 1: reset in the middle of a store's EXEC
        imem[0] = 3'd4; halt_addr = 10'd5;
        start = 1; cycle(0); start = 0;
        cycle(1);
        opcode = imem[pc[3:0]];
        #2;
        check("t1_memwe_pre", mem_we, 1);
        rst_n = 0;
        #1;
        check("t1_memwe_rst", mem_we, 0);
        check("t1_zero", {22'd0, dut_vec()}, 64'd0);
        m_reset();
        @(negedge clk);
        rst_n = 1;
        pc = '0;
        repeat (3) cycle(0);
        check("t1_idle", {busy, done}, 0);

        // 2: add, nand, move with halt at 2
        step = 1;
        imem[0] = 3'd0; imem[1] = 3'd2; imem[2] = 3'd5; halt_addr = 10'd2;
        run_prog(30);
        check("t2_pcrst", n_pcrst, 1);
        check("t2_ir", ir_mask, (32'd1 << 1) | (32'd1 << (3 + SW)) | (32'd1 << (5 + 2 * SW)));
        check("t2_icnt", instr_count, 3);
        check("t2_ccnt", cycle_count, 6 + 2 * SW);
        check("t2_pcen", n_pcen, 2);
        check("t2_busy", n_busy, 6 + 2 * SW);

        // 3: load then add
        imem[0] = 3'd3; imem[1] = 3'd0; halt_addr = 10'd1;
        run_prog(30);
        check("t3_ir", ir_mask, (32'd1 << 1) | (32'd1 << (4 + SW)));
        check("t3_re", re_mask, (32'd1 << 2) | (32'd1 << 3));
        check("t3_we", we_mask, (32'd1 << 3) | (32'd1 << (5 + SW)));
        check("t3_icnt", instr_count, 2);
        check("t3_ccnt", cycle_count, 5 + SW);

        // 4: BNE taken and not taken
        imem[0] = 3'd6; imem[1] = 3'd0; imem[2] = 3'd0; halt_addr = 10'd2;
        br_target = 10'd2; branch_taken = 1;
        run_prog(30);
        check("t4t_pcload", n_pcload, 1);
        check("t4t_pcen", n_pcen, 0);
        check("t4t_icnt", instr_count, 2);
        branch_taken = 0;
        run_prog(30);
        check("t4n_pcload", n_pcload, 0);
        check("t4n_pcen", n_pcen, 2);
        check("t4n_icnt", instr_count, 3);

        // 5: BNE self-loop, halt never reached, watchdog fires
        imem[0] = 3'd6; br_target = 10'd0; branch_taken = 1; halt_addr = 10'd5;
        run_prog(60);
        check("t5_ccnt", cycle_count, MAXC);
        check("t5_timeout", timeout, 1);
        check("t5_done", done, 1);
        start = 1; cycle(0); start = 0;
        check("t5_re_ccnt", cycle_count, 0);
        check("t5_re_timeout", timeout, 0);
        check("t5_re_fetch", ir_en, 1);
        repeat (3) cycle(1);

`ifdef SEQ_STEP_EN
        // 6: single-step pause after a non-halting retire
        rst_n = 0;
        #1;
        m_reset();
        @(negedge clk);
        rst_n = 1;
        imem[0] = 3'd0; imem[1] = 3'd0; halt_addr = 10'd1; step = 0;
        start = 1; cycle(0); start = 0;
        cycle(1);
        cycle(2);
        repeat (3) cycle(3);
        check("t6_wait_strobes", {pc_rst, pc_en, pc_load, ir_en, reg_we, mem_re, mem_we}, 0);
        check("t6_wait_busy", busy, 1);
        step = 1; cycle(4); step = 0;
        check("t6_fetch", ir_en, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
